// File: rtl/br_pkg.sv
// Shared encodings for the EX-stage branch resolver: opcodes, FSM states, link register.
// Optional statistics counters in branch_resolve are enabled by BR_RESOLVE_STATS_EN.
package br_pkg;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_B    = 4'd7,
    BR_BL   = 4'd8,
    BR_JIRL = 4'd9
  } br_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } br_state_e;

  localparam logic [4:0] LINK_REG = 5'd1;

  // BL always links through r1; JIRL links through its own rd field.
  function automatic logic [4:0] link_dest(input logic [3:0] br_type,
                                           input logic [4:0] rd_idx);
    return (br_type == BR_BL) ? LINK_REG : rd_idx;
  endfunction

  function automatic logic is_branch(input logic [3:0] br_type);
    return (br_type >= BR_BEQ) && (br_type <= BR_JIRL);
  endfunction

  function automatic logic is_link(input logic [3:0] br_type);
    return (br_type == BR_BL) || (br_type == BR_JIRL);
  endfunction

endpackage

// File: rtl/br_cmp.sv
// 32-bit operand comparator: equality, signed less-than, unsigned less-than.
module br_cmp (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq,
  output logic        sl,
  output logic        ul
);

  assign eq = (a == b);
  assign sl = ($signed(a) < $signed(b));
  assign ul = (a < b);

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolver: decides taken/target, holds a redirect until fetch accepts it.
// Define BR_RESOLVE_STATS_EN to add the br_cnt / taken_cnt statistics outputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | resolving EX instructions; taken branch launches a redirect
// ST_REQ   | redirect_valid high, waiting for if_ready
// ST_DRAIN | one bubble after acceptance; EX still treated as wrong path
module branch_resolve
  import br_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [3:0]  br_type,
  input  logic [31:0] rj_data,
  input  logic [31:0] rd_data,
  input  logic [31:0] pc_ex,
  input  logic [31:0] offs,
  input  logic        if_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        br_busy,
  output logic        link_we,
  output logic [31:0] link_data
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [31:0] br_cnt,
  output logic [31:0] taken_cnt
`endif
);

  br_state_e   state_q, state_d;
  logic [31:0] target_q, target_d;
  logic        flush_q, flush_d;

  logic        cmp_eq, cmp_sl, cmp_ul;
  logic        taken;
  logic        resolve;
  logic [31:0] target_base;
  logic [31:0] target_calc;

  br_cmp u_cmp (
    .a  (rj_data),
    .b  (rd_data),
    .eq (cmp_eq),
    .sl (cmp_sl),
    .ul (cmp_ul)
  );

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_BEQ:  taken = cmp_eq;
      BR_BNE:  taken = !cmp_eq;
      BR_BLT:  taken = cmp_sl;
      BR_BGE:  taken = !cmp_sl;
      BR_BLTU: taken = cmp_ul;
      BR_BGEU: taken = !cmp_ul;
      BR_B,
      BR_BL,
      BR_JIRL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Word-aligned target; low bits dropped by mask so the full sum stays used.
  assign target_base = (br_type == BR_JIRL) ? rj_data : pc_ex;
  assign target_calc = (target_base + offs) & 32'hFFFF_FFFC;

  // Only IDLE looks at EX; in REQ/DRAIN the EX slot holds wrong-path work.
  assign resolve = (state_q == ST_IDLE) && ex_valid && !ex_stall;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    flush_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (resolve && taken) begin
          state_d  = ST_REQ;
          target_d = target_calc;
          flush_d  = 1'b1;
        end
      end
      ST_REQ: begin
        if (if_ready) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      flush_q  <= flush_d;
    end
  end

  assign redirect_valid = (state_q == ST_REQ);
  assign redirect_pc    = target_q;
  assign flush          = flush_q;
  assign br_busy        = (state_q != ST_IDLE);
  assign link_we        = !rst && resolve && is_link(br_type);
  assign link_data      = pc_ex + 32'd4;

`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (resolve && is_branch(br_type)) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (taken) taken_cnt_d = taken_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign br_cnt    = br_cnt_q;
  assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized traffic vs a cycle model.
module tb_branch_resolve;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_stall;
  logic [3:0]  br_type;
  logic [31:0] rj_data;
  logic [31:0] rd_data;
  logic [31:0] pc_ex;
  logic [31:0] offs;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        br_busy;
  logic        link_we;
  logic [31:0] link_data;
`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] taken_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // model: a pending redirect, a one-cycle drain marker, a flush marker
  logic        m_pend;
  logic        m_drain;
  logic        m_flush;
  logic [31:0] m_tgt;
  logic [31:0] m_br;
  logic [31:0] m_tk;

  branch_resolve dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .br_type        (br_type),
    .rj_data        (rj_data),
    .rd_data        (rd_data),
    .pc_ex          (pc_ex),
    .offs           (offs),
    .if_ready       (if_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .br_busy        (br_busy),
    .link_we        (link_we),
    .link_data      (link_data)
`ifdef BR_RESOLVE_STATS_EN
    ,
    .br_cnt         (br_cnt),
    .taken_cnt      (taken_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic ref_taken(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      4'd1: return a == b;
      4'd2: return a != b;
      4'd3: return $signed(a) < $signed(b);
      4'd4: return $signed(a) >= $signed(b);
      4'd5: return a < b;
      4'd6: return a >= b;
      4'd7, 4'd8, 4'd9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [3:0] t, input logic [31:0] rj,
                                             input logic [31:0] pc, input logic [31:0] o);
    logic [31:0] s;
    s = ((t == 4'd9) ? rj : pc) + o;
    return {s[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] edge_val(input int k);
    case (k)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic model_step();
    logic idle;
    idle = !m_pend && !m_drain;
    if (rst) begin
      m_pend = 0; m_drain = 0; m_flush = 0; m_tgt = '0; m_br = '0; m_tk = '0;
    end else begin
      if (idle && ex_valid && !ex_stall && br_type >= 4'd1 && br_type <= 4'd9) begin
        m_br = m_br + 1;
        if (ref_taken(br_type, rj_data, rd_data)) m_tk = m_tk + 1;
      end
      m_flush = 0;
      if (m_pend) begin
        if (if_ready) begin m_pend = 0; m_drain = 1; end
      end else if (m_drain) begin
        m_drain = 0;
      end else if (ex_valid && !ex_stall && ref_taken(br_type, rj_data, rd_data)) begin
        m_pend = 1; m_flush = 1; m_tgt = ref_target(br_type, rj_data, pc_ex, offs);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] t, input logic [31:0] rj, input logic [31:0] rd,
                       input logic [31:0] pc, input logic [31:0] o);
    ex_valid = 1'b1; ex_stall = 1'b0;
    br_type = t; rj_data = rj; rd_data = rd; pc_ex = pc; offs = o;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_ready = 1'b0;
    drive(4'd8, 32'h0, 32'h0, 32'h500, 32'h40);
    tick(); tick();
    #2;
    n_checks++;
    if ({redirect_valid, flush, br_busy, link_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: rv/flush/busy/lwe = %b required 0000", {redirect_valid, flush, br_busy, link_we});
    end
    n_checks++;
    if (redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h required 00000000", redirect_pc);
    end
`ifdef BR_RESOLVE_STATS_EN
    n_checks++;
    if (br_cnt !== 32'h0 || taken_cnt !== 32'h0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d required 0/0", br_cnt, taken_cnt);
    end
`endif
    rst = 1'b0; ex_valid = 1'b0;
    tick();
  endtask

  task automatic test_blt_taken();
    drive(4'd3, 32'hFFFF_FFFF, 32'h1, 32'h1000, 32'h20);
    if_ready = 1'b0;
    #2;
    n_checks++;
    if (redirect_valid !== 1'b0 || link_we !== 1'b0) begin
      n_fail++; $display("FAIL blt_pre: rv=%b lwe=%b required 0 0", redirect_valid, link_we);
    end
    tick();
    ex_valid = 1'b0;
    #2;
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1020 || flush !== 1'b1 || br_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL blt_req: rv=%b pc=%h flush=%b busy=%b required 1 00001020 1 1",
               redirect_valid, redirect_pc, flush, br_busy);
    end
    if_ready = 1'b1;
    tick();
    #2;
    n_checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || br_busy !== 1'b1) begin
      n_fail++; $display("FAIL blt_drain: rv=%b flush=%b busy=%b required 0 0 1", redirect_valid, flush, br_busy);
    end
    tick();
    #2;
    n_checks++;
    if (br_busy !== 1'b0) begin
      n_fail++; $display("FAIL blt_idle: busy=%b required 0", br_busy);
    end
  endtask

  task automatic test_bltu_not_taken();
    drive(4'd5, 32'hFFFF_FFFF, 32'h1, 32'h1000, 32'h20);
    if_ready = 1'b1;
    tick();
    drive(4'd1, 32'h5, 32'h5, 32'h2000, 32'h40);
    ex_stall = 1'b1;
    #2;
    n_checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || br_busy !== 1'b0) begin
      n_fail++; $display("FAIL bltu_nt: rv=%b flush=%b busy=%b required 0 0 0", redirect_valid, flush, br_busy);
    end
    tick();
    ex_valid = 1'b0; ex_stall = 1'b0;
    #2;
    n_checks++;
    if (redirect_valid !== 1'b0 || br_busy !== 1'b0) begin
      n_fail++; $display("FAIL stalled_beq: rv=%b busy=%b required 0 0", redirect_valid, br_busy);
    end
  endtask

  task automatic test_jirl();
    drive(4'd9, 32'h2003, 32'h0, 32'h3000, 32'h4);
    if_ready = 1'b1;
    #2;
    n_checks++;
    if (link_we !== 1'b1 || link_data !== 32'h3004) begin
      n_fail++; $display("FAIL jirl_link: lwe=%b data=%h required 1 00003004", link_we, link_data);
    end
    tick();
    ex_valid = 1'b0;
    #2;
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2004) begin
      n_fail++; $display("FAIL jirl_target: rv=%b pc=%h required 1 00002004", redirect_valid, redirect_pc);
    end
    tick(); tick();
  endtask

  task automatic test_ready_stall();
    int flushes;
    flushes = 0;
    drive(4'd1, 32'h77, 32'h77, 32'h4000, 32'hFFFF_FFF0);
    if_ready = 1'b0;
    tick();
    drive(4'd8, 32'h0, 32'h0, 32'h0, 32'h100);
    for (int i = 0; i < 4; i++) begin
      if_ready = (i == 3);
      #2;
      if (flush === 1'b1) flushes++;
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3FF0 || link_we !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_req[%0d]: rv=%b pc=%h lwe=%b required 1 00003ff0 0", i, redirect_valid, redirect_pc, link_we);
      end
      tick();
    end
    #2;
    n_checks++;
    if (redirect_valid !== 1'b0 || br_busy !== 1'b1 || link_we !== 1'b0 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drain: rv=%b busy=%b lwe=%b flush=%b required 0 1 0 0", redirect_valid, br_busy, link_we, flush);
    end
    n_checks++;
    if (flushes !== 1) begin
      n_fail++; $display("FAIL hold_flush_count: got %0d required 1", flushes);
    end
    ex_valid = 1'b0;
    tick();
    #2;
    n_checks++;
    if (br_busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_idle: busy=%b required 0", br_busy);
    end
  endtask

  task automatic test_rst_in_req();
    drive(4'd7, 32'h0, 32'h0, 32'h8000, 32'h100);
    if_ready = 1'b0;
    tick();
    ex_valid = 1'b0;
    #2;
    n_checks++;
    if (redirect_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_req_enter: rv=%b required 1", redirect_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    n_checks++;
    if ({redirect_valid, flush, br_busy, link_we} !== 4'b0000 || redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_req_clear: rv/flush/busy/lwe=%b pc=%h required 0000 00000000",
               {redirect_valid, flush, br_busy, link_we}, redirect_pc);
    end
    if_ready = 1'b1;
    tick();
    #2;
    n_checks++;
    if ({redirect_valid, flush, br_busy} !== 3'b000) begin
      n_fail++; $display("FAIL rst_req_after: rv/flush/busy=%b required 000", {redirect_valid, flush, br_busy});
    end
  endtask

  task automatic test_back_to_back();
    int first, last, cnt, min_gap;
    first = -1; last = -1; cnt = 0; min_gap = 99;
    drive(4'd7, 32'h0, 32'h0, 32'h100, 32'h8);
    if_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (flush === 1'b1) begin
        if (first < 0) first = i;
        if (last >= 0 && (i - last) < min_gap) min_gap = i - last;
        last = i;
        cnt++;
      end
      tick();
    end
    n_checks++;
    if (cnt !== 3 || first !== 1 || min_gap !== 3) begin
      n_fail++; $display("FAIL back_to_back: flushes=%0d first=%0d gap=%0d required 3 1 3", cnt, first, min_gap);
    end
    ex_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic exp_busy, exp_lwe;
    int mode;
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_stall = ($urandom_range(0, 4) == 0);
      br_type  = 4'($urandom_range(0, 11));
      if_ready = ($urandom_range(0, 2) != 0);
      pc_ex    = $urandom;
      offs     = $urandom;
      mode     = $urandom_range(0, 3);
      rj_data  = (mode == 2) ? edge_val($urandom_range(0, 4)) : $urandom;
      case (mode)
        0: rd_data = rj_data;
        2: rd_data = edge_val($urandom_range(0, 4));
        3: rd_data = rj_data + 32'd1;
        default: rd_data = $urandom;
      endcase
      #2;
      exp_busy = m_pend || m_drain;
      exp_lwe  = !rst && !exp_busy && ex_valid && !ex_stall && (br_type == 4'd8 || br_type == 4'd9);
      n_checks++;
      if (redirect_valid !== m_pend || flush !== m_flush || br_busy !== exp_busy) begin
        n_fail++;
        $display("FAIL rnd_ctrl[%0d]: rv/flush/busy=%b%b%b required %b%b%b", n,
                 redirect_valid, flush, br_busy, m_pend, m_flush, exp_busy);
      end
      n_checks++;
      if (redirect_pc !== m_tgt) begin
        n_fail++; $display("FAIL rnd_pc[%0d]: got %h required %h", n, redirect_pc, m_tgt);
      end
      n_checks++;
      if (link_we !== exp_lwe || link_data !== pc_ex + 32'd4) begin
        n_fail++;
        $display("FAIL rnd_link[%0d]: lwe=%b data=%h required %b %h", n, link_we, link_data, exp_lwe, pc_ex + 32'd4);
      end
`ifdef BR_RESOLVE_STATS_EN
      n_checks++;
      if (br_cnt !== m_br || taken_cnt !== m_tk) begin
        n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d required %0d/%0d", n, br_cnt, taken_cnt, m_br, m_tk);
      end
`endif
      tick();
    end
    rst = 1'b0; ex_valid = 1'b0; if_ready = 1'b1;
    tick(); tick(); tick();
  endtask

`ifdef BR_RESOLVE_STATS_EN
  task automatic test_stats();
    rst = 1'b1; ex_valid = 1'b0;
    tick();
    rst = 1'b0; if_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: drive(4'd1, 32'h9, 32'h9, 32'h100, 32'h10);
        1: drive(4'd2, 32'h9, 32'h9, 32'h200, 32'h10);
        2: drive(4'd0, 32'h0, 32'h0, 32'h280, 32'h10);
        3: drive(4'd7, 32'h0, 32'h0, 32'h300, 32'h10);
        4: drive(4'd5, 32'h9, 32'h1, 32'h400, 32'h10);
        default: drive(4'd9, 32'h600, 32'h0, 32'h500, 32'h10);
      endcase
      tick();
      ex_valid = 1'b0;
      tick(); tick();
    end
    #2;
    n_checks++;
    if (br_cnt !== 32'd5 || taken_cnt !== 32'd3) begin
      n_fail++; $display("FAIL stats: br_cnt=%0d taken_cnt=%0d required 5 3", br_cnt, taken_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    m_pend = 0; m_drain = 0; m_flush = 0; m_tgt = '0; m_br = '0; m_tk = '0;
    rst = 1'b1; ex_valid = 1'b0; ex_stall = 1'b0; br_type = 4'd0;
    rj_data = '0; rd_data = '0; pc_ex = '0; offs = '0; if_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_blt_taken();
    test_bltu_not_taken();
    test_jirl();
    test_ready_stall();
    test_rst_in_req();
    test_back_to_back();
    test_random();
`ifdef BR_RESOLVE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
